// File: rtl/uart_rx_frame.sv
// Serial receive stage: 2-flop synchronised rx, mid-bit sampling, optional parity,
// single-entry valid/ready output buffer with parity, framing and overrun reporting.
module uart_rx_frame #(
    parameter int unsigned BR         = 434,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_vld,
    input  logic                 rx_rdy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int unsigned CNT_W = (BR > 1) ? $clog2(BR) : 1;
    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BR - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BR / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_e;

    state_e               state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_vld_q, rx_vld_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 deliver;
    logic                 bit_end;
    logic                 half_bit;

    // Line synchroniser presets high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_vld_q     <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            perr_q       <= perr_d;
            rx_data_q    <= rx_data_d;
            rx_vld_q     <= rx_vld_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bit_end  = (cnt_q == CNT_LAST);
    assign half_bit = (cnt_q == CNT_HALF);

    // Frame sequencing; cnt_q free-runs inside a bit and restarts at each sample point.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        idx_d       = idx_q;
        shift_d     = shift_q;
        perr_d      = perr_q;
        frame_err_d = 1'b0;
        deliver     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (half_bit) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        idx_d   = '0;
                        perr_d  = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    perr_d  = (^shift_q) ^ rx_s_q ^ 1'(PARITY_ODD);
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        deliver = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output buffer: a completed frame loads only if the slot is empty or draining this cycle.
    always_comb begin
        rx_data_d    = rx_data_q;
        parity_err_d = parity_err_q;
        rx_vld_d     = rx_vld_q;
        overrun_d    = 1'b0;

        if (rx_vld_q && rx_rdy) begin
            rx_vld_d = 1'b0;
        end
        if (deliver) begin
            if (!rx_vld_q || rx_rdy) begin
                rx_data_d    = shift_q;
                parity_err_d = perr_q;
                rx_vld_d     = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_vld     = rx_vld_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at BR=16, 8 data bits, even parity.
module tb_uart_rx_frame;

    localparam int unsigned BR = 16;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_vld;
    logic       rx_rdy;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    int vectors;
    int errs;

    int acc_cnt;
    int vld_cycles;
    int ferr_cnt;
    int ovr_cnt;
    logic [7:0] last_data;
    logic       last_perr;

    int a0, v0, f0, o0;

    uart_rx_frame #(
        .BR         (BR),
        .DATA_BITS  (8),
        .PARITY_EN  (1),
        .PARITY_ODD (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_vld     (rx_vld),
        .rx_rdy     (rx_rdy),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event tallies, sampled mid-cycle while inputs are stable.
    initial begin
        acc_cnt = 0; vld_cycles = 0; ferr_cnt = 0; ovr_cnt = 0;
        last_data = '0; last_perr = 1'b0;
    end
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_vld) vld_cycles = vld_cycles + 1;
            if (rx_vld && rx_rdy) begin
                acc_cnt   = acc_cnt + 1;
                last_data = rx_data;
                last_perr = parity_err;
            end
            if (frame_err) ferr_cnt = ferr_cnt + 1;
            if (overrun)   ovr_cnt  = ovr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            errs = errs + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(BR);
    endtask

    // Start, 8 data bits LSB first, parity, stop; stop_low_bits extends a low stop bit.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int stop_low_bits);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stop);
        if (!stop) tick(BR * stop_low_bits);
        rx = 1'b1;
    endtask

    task automatic snap();
        a0 = acc_cnt; v0 = vld_cycles; f0 = ferr_cnt; o0 = ovr_cnt;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        vectors = 0;
        errs    = 0;
        rst     = 1'b1;
        rx      = 1'b1;
        rx_rdy  = 1'b1;
        tick(4);
        sample();
        check("rst_data",  32'(rx_data),    32'h0);
        check("rst_vld",   32'(rx_vld),     32'h0);
        check("rst_perr",  32'(parity_err), 32'h0);
        check("rst_ferr",  32'(frame_err),  32'h0);
        check("rst_ovr",   32'(overrun),    32'h0);
        tick(1);
        rst = 1'b0;
        tick(2 * BR);

        // 0xA5 good parity, consumer ready: one-cycle valid
        snap();
        send_frame(8'hA5, 1'b0, 1'b1, 0);
        tick(2 * BR);
        check("a5_acc",   32'(acc_cnt - a0),    32'd1);
        check("a5_data",  32'(last_data),       32'hA5);
        check("a5_perr",  32'(last_perr),       32'h0);
        check("a5_vldcy", 32'(vld_cycles - v0), 32'd1);
        check("a5_ferr",  32'(ferr_cnt - f0),   32'd0);
        check("a5_ovr",   32'(ovr_cnt - o0),    32'd0);

        // 0x3C with bad parity, held until accepted
        rx_rdy = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b1, 0);
        tick(2 * BR);
        sample();
        check("3c_vld",  32'(rx_vld),     32'h1);
        check("3c_data", 32'(rx_data),    32'h3C);
        check("3c_perr", 32'(parity_err), 32'h1);
        tick(1);
        rx_rdy = 1'b1;
        tick(1);
        sample();
        check("3c_vld_drop",  32'(rx_vld),     32'h0);
        check("3c_data_hold", 32'(rx_data),    32'h3C);
        check("3c_perr_hold", 32'(parity_err), 32'h1);
        check("3c_acc_perr",  32'(last_perr),  32'h1);
        tick(2 * BR);

        // 0x55 with low stop, line held low: one frame_err, nothing delivered
        snap();
        send_frame(8'h55, 1'b0, 1'b0, 40);
        tick(2 * BR);
        check("55_ferr",  32'(ferr_cnt - f0),   32'd1);
        check("55_vldcy", 32'(vld_cycles - v0), 32'd0);
        check("55_ovr",   32'(ovr_cnt - o0),    32'd0);
        snap();
        send_frame(8'h12, 1'b0, 1'b1, 0);
        tick(2 * BR);
        check("12_acc",  32'(acc_cnt - a0), 32'd1);
        check("12_data", 32'(last_data),    32'h12);
        check("12_perr", 32'(last_perr),    32'h0);
        check("12_ferr", 32'(ferr_cnt - f0), 32'd0);

        // Overrun: 0x01 held, 0x02 dropped
        rx_rdy = 1'b0;
        snap();
        send_frame(8'h01, 1'b1, 1'b1, 0);
        send_frame(8'h02, 1'b1, 1'b1, 0);
        tick(2 * BR);
        sample();
        check("ovr_pulse", 32'(ovr_cnt - o0), 32'd1);
        check("ovr_vld",   32'(rx_vld),       32'h1);
        check("ovr_data",  32'(rx_data),      32'h01);
        check("ovr_perr",  32'(parity_err),   32'h0);
        tick(1);
        rx_rdy = 1'b1;
        tick(1);
        sample();
        check("ovr_vld_drop", 32'(rx_vld),        32'h0);
        check("ovr_acc",      32'(acc_cnt - a0),  32'd1);
        check("ovr_acc_data", 32'(last_data),     32'h01);
        tick(2 * BR);

        // 5-clk glitch in idle is ignored
        snap();
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(2 * BR);
        check("gl_vldcy", 32'(vld_cycles - v0), 32'd0);
        check("gl_ferr",  32'(ferr_cnt - f0),   32'd0);
        check("gl_ovr",   32'(ovr_cnt - o0),    32'd0);
        send_frame(8'hFF, 1'b0, 1'b1, 0);
        tick(2 * BR);
        check("ff_acc",  32'(acc_cnt - a0), 32'd1);
        check("ff_data", 32'(last_data),    32'hFF);
        check("ff_perr", 32'(last_perr),    32'h0);

        // Reset in the middle of 0x77's data bits
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        tick(BR / 2);
        rst = 1'b1;
        rx  = 1'b1;
        tick(2);
        sample();
        check("mrst_data", 32'(rx_data),    32'h0);
        check("mrst_vld",  32'(rx_vld),     32'h0);
        check("mrst_perr", 32'(parity_err), 32'h0);
        check("mrst_ferr", 32'(frame_err),  32'h0);
        check("mrst_ovr",  32'(overrun),    32'h0);
        tick(1);
        rst = 1'b0;
        tick(2 * BR);
        snap();
        send_frame(8'h88, 1'b0, 1'b1, 0);
        tick(2 * BR);
        check("88_acc",  32'(acc_cnt - a0),  32'd1);
        check("88_data", 32'(last_data),     32'h88);
        check("88_perr", 32'(last_perr),     32'h0);
        check("88_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("88_ovr",  32'(ovr_cnt - o0),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
